// File: rtl/mem_wb_pipe_pkg.sv
// Shared encodings for the MEM/WB pipeline register: write-back source
// select (WB_*) and load-size (LD_*) codes used by mem_wb_pipe and load_align.
package mem_wb_pipe_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_RAM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10,
        LD_X = 2'b11
    } ld_size_e;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/mem_wb_pipe_load_align.sv
// load_align: combinational load-lane extraction and sign/zero extension.
// Ports: ram_data, ld_size, ld_unsigned, addr_lo in; o_ld_data (XLEN) out.
module load_align
    import mem_wb_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int LO_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] ram_data,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [LO_W-1:0] addr_lo,
    output logic [XLEN-1:0] o_ld_data
);

    logic [LO_W-1:0]   w_off_h;
    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;
    logic [XLEN-1:0]   w_byte_x;
    logic [XLEN-1:0]   w_half_x;
    logic [XLEN-1:0]   w_word_x;
    logic              w_sb;
    logic              w_sh;

    // Low address bits below the access size are ignored, so a
    // misaligned half simply reads its enclosing aligned lane.
    assign w_off_h = addr_lo & ~LO_W'(1);

    assign w_byte = ram_data[{addr_lo, 3'b000} +: BYTE_W];
    assign w_half = ram_data[{w_off_h, 3'b000} +: HALF_W];

    assign w_sb = !ld_unsigned && w_byte[BYTE_W-1];
    assign w_sh = !ld_unsigned && w_half[HALF_W-1];

    assign w_byte_x = {{(XLEN-BYTE_W){w_sb}}, w_byte};
    assign w_half_x = {{(XLEN-HALF_W){w_sh}}, w_half};

    // A word is the full datapath on RV32, so only RV64 needs a lane mux.
    generate
        if (XLEN > WORD_W) begin : g_word64
            logic [LO_W-1:0]   w_off_w;
            logic [WORD_W-1:0] w_word;
            logic              w_sw;
            assign w_off_w  = addr_lo & ~LO_W'(3);
            assign w_word   = ram_data[{w_off_w, 3'b000} +: WORD_W];
            assign w_sw     = !ld_unsigned && w_word[WORD_W-1];
            assign w_word_x = {{(XLEN-WORD_W){w_sw}}, w_word};
        end else begin : g_word32
            assign w_word_x = ram_data;
        end
    endgenerate

    always_comb begin
        o_ld_data = ram_data;
        unique case (ld_size)
            LD_B: o_ld_data = w_byte_x;
            LD_H: o_ld_data = w_half_x;
            LD_W: o_ld_data = w_word_x;
            LD_X: o_ld_data = ram_data;
        endcase
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline register with valid/ready handshake, flush,
// write-back source mux and load alignment ahead of the register.
// Ports: clk, rst (sync, high); in_valid/in_ready, flush, wb_sel, alu_data,
// ram_data, pc_plus4, imm_data, ld_size, ld_unsigned, addr_lo, reg_we_in,
// rd_in in; out_valid/out_ready, reg_we_out, rd_out, wb_data out.
// Define MEM_WB_RETIRE_CNT_EN to add the 32-bit retire_cnt output.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int LO_W   = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [1:0]        wb_sel,
    input  logic [XLEN-1:0]   alu_data,
    input  logic [XLEN-1:0]   ram_data,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [XLEN-1:0]   imm_data,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    input  logic [LO_W-1:0]   addr_lo,
    input  logic              reg_we_in,
    input  logic [REG_AW-1:0] rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              reg_we_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [XLEN-1:0]   wb_data
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_cnt
`endif
);

    logic              r_valid;
    logic              r_we;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_data;

    logic              w_load;
    logic [XLEN-1:0]   w_ld_data;
    logic [XLEN-1:0]   w_wb_next;

    load_align #(
        .XLEN (XLEN),
        .LO_W (LO_W)
    ) u_load_align (
        .ram_data    (ram_data),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .addr_lo     (addr_lo),
        .o_ld_data   (w_ld_data)
    );

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    always_comb begin
        w_wb_next = alu_data;
        unique case (wb_sel)
            WB_ALU: w_wb_next = alu_data;
            WB_RAM: w_wb_next = w_ld_data;
            WB_PC4: w_wb_next = pc_plus4;
            WB_IMM: w_wb_next = imm_data;
        endcase
    end

    // Flush kills both the held entry and any entry offered this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_we    <= reg_we_in;
            r_rd    <= rd_in;
            r_data  <= w_wb_next;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign rd_out     = r_rd;
    assign wb_data    = r_data;
    // x0 is hardwired, so writes to it are suppressed here.
    assign reg_we_out = r_we && r_valid && (r_rd != '0);

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (r_valid && out_ready) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: vector table on an RV32 instance
// with a queue scoreboard, hand sequences for stall/flush/reset, RV64 loads.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic [1:0]  wb_sel, ld_size, addr_lo;
    logic [31:0] alu_data, ram_data, pc_plus4, imm_data;
    logic        ld_unsigned, reg_we_in;
    logic [4:0]  rd_in;
    logic        out_valid, out_ready, reg_we_out;
    logic [4:0]  rd_out;
    logic [31:0] wb_data;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    logic [31:0] d_retire_cnt;
`endif

    logic        d_in_valid, d_in_ready, d_out_valid, d_we_out;
    logic [1:0]  d_ld_size;
    logic [2:0]  d_addr_lo;
    logic        d_uns;
    logic [63:0] d_ram, d_wb_data;
    logic [4:0]  d_rd_out;

    always #5 clk = ~clk;

    mem_wb_pipe u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .wb_sel      (wb_sel),
        .alu_data    (alu_data),
        .ram_data    (ram_data),
        .pc_plus4    (pc_plus4),
        .imm_data    (imm_data),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .addr_lo     (addr_lo),
        .reg_we_in   (reg_we_in),
        .rd_in       (rd_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .reg_we_out  (reg_we_out),
        .rd_out      (rd_out),
        .wb_data     (wb_data)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .retire_cnt  (retire_cnt)
`endif
    );

    mem_wb_pipe #(.XLEN(64)) u_dut64 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (d_in_valid),
        .in_ready    (d_in_ready),
        .flush       (1'b0),
        .wb_sel      (2'b01),
        .alu_data    (64'd0),
        .ram_data    (d_ram),
        .pc_plus4    (64'd0),
        .imm_data    (64'd0),
        .ld_size     (d_ld_size),
        .ld_unsigned (d_uns),
        .addr_lo     (d_addr_lo),
        .reg_we_in   (1'b1),
        .rd_in       (5'd1),
        .out_valid   (d_out_valid),
        .out_ready   (1'b1),
        .reg_we_out  (d_we_out),
        .rd_out      (d_rd_out),
        .wb_data     (d_wb_data)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .retire_cnt  (d_retire_cnt)
`endif
    );

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] ram;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lo;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] exp_d;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  lo;
        logic [63:0] exp_d;
    } v64_t;

    exp_t        sbq[$];
    exp_t        cur_exp;
    int          n_vec = 0;
    int          n_bad = 0;
    logic        m_valid;
    logic        m_zero;
    logic [31:0] m_cnt;

    vec_t tbl[14];
    v64_t t64[6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance model, drive after edge.
    task automatic tick();
        exp_t e;
        logic ld;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sbq[0];
                chk("reg_we_out", 64'(reg_we_out), 64'(e.we));
                chk("rd_out", 64'(rd_out), 64'(e.rd));
                chk("wb_data", 64'(wb_data), 64'(e.d));
            end
        end else begin
            chk("reg_we_idle", 64'(reg_we_out), 64'd0);
            if (m_zero) begin
                chk("rd_zero", 64'(rd_out), 64'd0);
                chk("data_zero", 64'(wb_data), 64'd0);
            end
        end
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
`endif
        ld = in_valid && (!m_valid || out_ready) && !flush;
        if (rst) begin
            m_valid = 1'b0;
            m_zero  = 1'b1;
            m_cnt   = '0;
            sbq.delete();
        end else begin
            if (m_valid && sbq.size() > 0) begin
                if (out_ready) begin
                    void'(sbq.pop_front());
                    m_cnt = m_cnt + 32'd1;
                end else if (flush) begin
                    void'(sbq.pop_front());
                end
            end
            if (flush) begin
                m_valid = 1'b0;
            end else if (ld) begin
                sbq.push_back(cur_exp);
                m_valid = 1'b1;
                m_zero  = 1'b0;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [31:0] a, input logic [4:0] rd);
        in_valid  = 1'b1;
        wb_sel    = 2'b00;
        alu_data  = a;
        rd_in     = rd;
        reg_we_in = 1'b1;
        cur_exp   = '{1'b1, rd, a};
    endtask

    initial begin
        tbl[0]  = '{2'b01, 32'h884422F0, 2'b00, 1'b0, 2'd0, 32'h0, 32'h0,
                    32'h0, 5'd1, 1'b1, 32'hFFFFFFF0, 1'b1};
        tbl[1]  = '{2'b01, 32'h884422F0, 2'b00, 1'b1, 2'd0, 32'h0, 32'h0,
                    32'h0, 5'd2, 1'b1, 32'h000000F0, 1'b1};
        tbl[2]  = '{2'b01, 32'h884422F0, 2'b01, 1'b0, 2'd2, 32'h0, 32'h0,
                    32'h0, 5'd3, 1'b1, 32'hFFFF8844, 1'b1};
        tbl[3]  = '{2'b01, 32'h884422F0, 2'b01, 1'b1, 2'd2, 32'h0, 32'h0,
                    32'h0, 5'd4, 1'b1, 32'h00008844, 1'b1};
        tbl[4]  = '{2'b01, 32'h884422F0, 2'b00, 1'b0, 2'd1, 32'h0, 32'h0,
                    32'h0, 5'd5, 1'b1, 32'h00000022, 1'b1};
        tbl[5]  = '{2'b01, 32'h884422F0, 2'b00, 1'b0, 2'd3, 32'h0, 32'h0,
                    32'h0, 5'd6, 1'b1, 32'hFFFFFF88, 1'b1};
        tbl[6]  = '{2'b01, 32'h884422F0, 2'b01, 1'b0, 2'd0, 32'h0, 32'h0,
                    32'h0, 5'd7, 1'b1, 32'h000022F0, 1'b1};
        tbl[7]  = '{2'b01, 32'h884422F0, 2'b01, 1'b1, 2'd3, 32'h0, 32'h0,
                    32'h0, 5'd8, 1'b1, 32'h00008844, 1'b1};
        tbl[8]  = '{2'b01, 32'h884422F0, 2'b10, 1'b0, 2'd2, 32'h0, 32'h0,
                    32'h0, 5'd9, 1'b1, 32'h884422F0, 1'b1};
        tbl[9]  = '{2'b01, 32'h884422F0, 2'b11, 1'b0, 2'd1, 32'h0, 32'h0,
                    32'h0, 5'd10, 1'b1, 32'h884422F0, 1'b1};
        tbl[10] = '{2'b00, 32'h884422F0, 2'b00, 1'b0, 2'd3, 32'h1234,
                    32'h0, 32'h0, 5'd11, 1'b1, 32'h00001234, 1'b1};
        tbl[11] = '{2'b10, 32'h0, 2'b00, 1'b0, 2'd0, 32'h0, 32'h104,
                    32'h0, 5'd0, 1'b1, 32'h00000104, 1'b0};
        tbl[12] = '{2'b11, 32'h0, 2'b01, 1'b0, 2'd0, 32'h0, 32'h0,
                    32'hABCD0000, 5'd5, 1'b0, 32'hABCD0000, 1'b0};
        tbl[13] = '{2'b01, 32'h884422F0, 2'b00, 1'b0, 2'd2, 32'h0, 32'h0,
                    32'h0, 5'd31, 1'b1, 32'h00000044, 1'b1};

        t64[0] = '{2'b10, 1'b0, 3'd4, 64'hFFFFFFFF_80000001};
        t64[1] = '{2'b10, 1'b1, 3'd4, 64'h00000000_80000001};
        t64[2] = '{2'b10, 1'b0, 3'd0, 64'h00000000_00000002};
        t64[3] = '{2'b01, 1'b0, 3'd6, 64'hFFFFFFFF_FFFF8000};
        t64[4] = '{2'b00, 1'b1, 3'd7, 64'h00000000_00000080};
        t64[5] = '{2'b11, 1'b0, 3'd5, 64'h80000001_00000002};

        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        wb_sel = 2'b00; ld_size = 2'b00; addr_lo = 2'd0;
        alu_data = '0; ram_data = '0; pc_plus4 = '0; imm_data = '0;
        ld_unsigned = 1'b0; reg_we_in = 1'b0; rd_in = '0;
        d_in_valid = 1'b0; d_ld_size = 2'b00; d_addr_lo = '0;
        d_uns = 1'b0; d_ram = '0;
        cur_exp = '{1'b0, 5'd0, 32'd0};
        repeat (2) @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_zero  = 1'b1;
        m_cnt   = '0;

        // reset state
        tick();
        rst = 1'b0;
        tick();

        // table vectors, back-to-back with consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid    = 1'b1;
            wb_sel      = tbl[i].sel;
            ram_data    = tbl[i].ram;
            ld_size     = tbl[i].size;
            ld_unsigned = tbl[i].uns;
            addr_lo     = tbl[i].lo;
            alu_data    = tbl[i].alu;
            pc_plus4    = tbl[i].pc4;
            imm_data    = tbl[i].imm;
            rd_in       = tbl[i].rd;
            reg_we_in   = tbl[i].we;
            cur_exp     = '{tbl[i].exp_we, tbl[i].rd, tbl[i].exp_d};
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();

        // stall three cycles, then retire; new offer must be refused
        out_ready = 1'b0;
        drive_alu(32'h1234, 5'd7);
        tick();
        drive_alu(32'hDEAD, 5'd9);
        repeat (3) tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // flush of a stalled entry with a simultaneous offer
        out_ready = 1'b0;
        drive_alu(32'h55, 5'd3);
        tick();
        drive_alu(32'h66, 5'd4);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();

        // reset during a stall drops the held entry
        out_ready = 1'b0;
        drive_alu(32'h77, 5'd4);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        drive_alu(32'h99, 5'd2);
        tick();
        in_valid = 1'b0;
        tick();
        tick();

        // RV64 load alignment, latency one cycle
        d_ram = 64'h80000001_00000002;
        for (int i = 0; i < 6; i++) begin
            d_in_valid = 1'b1;
            d_ld_size  = t64[i].size;
            d_uns      = t64[i].uns;
            d_addr_lo  = t64[i].lo;
            @(posedge clk);
            @(negedge clk);
            chk("d64_valid", 64'(d_out_valid), 64'd1);
            chk("d64_data", d_wb_data, t64[i].exp_d);
            #4;
        end
        d_in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
